sum_accumulator: RTL
====================

SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 SHALL have port Clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port Reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port Start, input, 1 bit: begins a run; sampled only in IDLE.
REQ-004 SHALL have port Count, input, 4 bits: samples per run, latched at Start; 0 means 16.
REQ-005 SHALL have port In_valid, input, 1 bit: SUM/C_out carry a valid sample this cycle.
REQ-006 SHALL have port SUM, input, 4 bits: sum from the upstream registered 4-bit adder stage.
REQ-007 SHALL have port C_out, input, 1 bit: carry from the same adder stage.
REQ-008 SHALL have port Out_ready, input, 1 bit: consumer accepts Total this cycle.
REQ-009 SHALL have port Total, output, 8 bits: accumulated result of the run.
REQ-010 SHALL have port Out_valid, output, 1 bit: Total is valid and held.
REQ-011 SHALL have port Busy, output, 1 bit: high in ACC and DONE.
REQ-012 SHALL have port Overflow, output, 1 bit: sticky flag, set if any addition in the run exceeded 255.

Function
REQ-013 SHALL form each sample as the 5-bit unsigned value {C_out, SUM}, range 0..31.
REQ-014 SHALL implement an FSM with states IDLE, ACC and DONE.
REQ-015 In IDLE with Start=1, SHALL on the edge latch Count (0 becomes 16), clear the accumulator, clear Overflow, and enter ACC.
REQ-016 In ACC, SHALL accept a sample on each edge where In_valid=1, add it to the accumulator and decrement the remaining count; cycles with In_valid=0 change nothing.
REQ-017 SHALL compute each addition 9 bits wide; without the macro, the accumulator takes the low 8 bits (wrap); bit 8 set SHALL set Overflow.
REQ-018 On the edge accepting the final sample, SHALL enter DONE; Out_valid=1 and Total, including the final sample, are visible in the following cycle.
REQ-019 In DONE, SHALL hold Total, Overflow and Out_valid stable while Out_ready=0.
REQ-020 In DONE with Out_ready=1, SHALL complete the transfer and return to IDLE on that edge; Out_valid=0 in the following cycle.
REQ-021 SHALL ignore Start in ACC and DONE, including a Start coincident with the DONE transfer; a new run requires Start in IDLE.
REQ-022 SHALL ignore In_valid outside ACC.
REQ-023 Total SHALL hold its last value in IDLE until the next Start clears it.
REQ-024 Busy SHALL equal (state != IDLE).

Reset
REQ-025 Reset_n=0 SHALL immediately, without a clock edge, force state IDLE, Total=0, Out_valid=0, Busy=0, Overflow=0, and clear the remaining count and latched Count.
REQ-026 Reset asserted mid-run (ACC or DONE) SHALL abandon the run; after release the block SHALL wait for a new Start.
REQ-027 Reset release SHALL take effect from the first rising edge after Reset_n rises.

Configuration
REQ-028 Macro SUM_ACC_SATURATE_EN: when defined, an addition exceeding 255 SHALL clamp the accumulator to 255, and it stays 255 for the rest of the run; Overflow still sets.
REQ-029 When SUM_ACC_SATURATE_EN is undefined, accumulation SHALL wrap modulo 256 per REQ-017.

Verification
REQ-030 Basic run: Count=3; samples {C_out,SUM} = 5, 7, {1,0011}=19 on consecutive cycles; Out_ready=1 -> Out_valid high for exactly one cycle, Total=31, Overflow=0, then back in IDLE.
REQ-031 Gaps and backpressure: Count=2; samples 10 and 20 separated by 3 In_valid=0 cycles; Out_ready low for 5 cycles -> Total=30 held with Out_valid=1 for all 5 cycles, transfer on the 6th.
REQ-032 Overflow: Count=0 (16 samples), every sample 31 -> Total=240 and Overflow=1 without the macro; Total=255 and Overflow=1 with SUM_ACC_SATURATE_EN.
REQ-033 Reset mid-run: Count=4, 2 samples accepted, Reset_n pulsed low between edges -> outputs zero immediately; a later Start with Count=1 and sample 9 gives Total=9.
REQ-034 Ignored Start: Start asserted during ACC and again coincident with the DONE transfer -> Count is not re-latched, Total is unaffected, FSM returns to IDLE and stays there.

Source files
------------

// File: rtl/sum_accumulator.sv
// -----------------------------------------------------------------------------
// sum_accumulator
//
// Purpose:
//   Accumulates a run of 5-bit samples {C_out, SUM} taken from an upstream
//   registered 4-bit adder stage into an 8-bit total. A run starts with Start
//   in IDLE, the number of samples is latched from Count (0 means 16), samples
//   are accepted whenever In_valid is high, and the result is then offered
//   with a valid/ready handshake (Out_valid/Out_ready).
//
// Ports:
//   Clock      in   1  rising-edge clock
//   Reset_n    in   1  asynchronous active-low reset
//   Start      in   1  begins a run (sampled only in IDLE)
//   Count      in   4  samples per run, latched at Start; 0 means 16
//   In_valid   in   1  SUM/C_out carry a valid sample this cycle
//   SUM        in   4  sum from the upstream adder stage
//   C_out      in   1  carry from the upstream adder stage
//   Out_ready  in   1  consumer accepts Total this cycle
//   Total      out  8  accumulated result of the run
//   Out_valid  out  1  Total is valid and held
//   Busy       out  1  high while a run is in progress (ACC or DONE)
//   Overflow   out  1  sticky: some addition of the run exceeded 255
//
// Configuration:
//   SUM_ACC_SATURATE_EN  when defined, the accumulator clamps at 255 instead
//                        of wrapping modulo 256. Overflow is set either way.
// -----------------------------------------------------------------------------
module sum_accumulator (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic       Start,
  input  logic [3:0] Count,
  input  logic       In_valid,
  input  logic [3:0] SUM,
  input  logic       C_out,
  input  logic       Out_ready,
  output logic [7:0] Total,
  output logic       Out_valid,
  output logic       Busy,
  output logic       Overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q;
  // Latched sample count, decremented per accepted sample (1..16 during a run).
  logic [4:0] remaining_q;
  logic [7:0] total_q;
  logic       ovf_q;
  logic       out_valid_q;
  logic       busy_q;

  logic [8:0] sum9_d;
  logic [7:0] total_d;
  logic [4:0] count_d;

  // Next accumulator value: 9-bit add, then wrap or clamp depending on build.
  always_comb begin
    sum9_d = {1'b0, total_q} + {4'b0000, C_out, SUM};
`ifdef SUM_ACC_SATURATE_EN
    // Once clamped at 255, any further non-zero sample overflows again and
    // re-clamps, so the total stays 255 for the rest of the run.
    if (sum9_d[8]) begin
      total_d = 8'hFF;
    end else begin
      total_d = sum9_d[7:0];
    end
`else
    total_d = sum9_d[7:0];
`endif
    if (Count == 4'd0) begin
      count_d = 5'd16;
    end else begin
      count_d = {1'b0, Count};
    end
  end

  // Run control FSM with all outputs registered.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      remaining_q <= 5'd0;
      total_q     <= 8'd0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Start) begin
            state_q     <= ACC;
            remaining_q <= count_d;
            total_q     <= 8'd0;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        ACC: begin
          if (In_valid) begin
            total_q     <= total_d;
            ovf_q       <= ovf_q | sum9_d[8];
            remaining_q <= remaining_q - 5'd1;
            // Last sample of the run: result becomes visible next cycle.
            if (remaining_q == 5'd1) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          // Start is deliberately not looked at here; a new run needs IDLE.
          if (Out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign Total     = total_q;
  assign Out_valid = out_valid_q;
  assign Busy      = busy_q;
  assign Overflow  = ovf_q;

endmodule
